// File: rtl/layer_inter_bank_control_if.sv
// Bus bundle between the inter-bank controller and its surroundings:
// producer layer, consumer layer, and the NUM_BANKS feature-map RAM banks.
// The controller connects through the slave modport; the environment
// (layers plus RAM banks, or a testbench) connects through master.
interface layer_inter_bank_control_if #(
  parameter int NUM_BANKS  = 2,
  parameter int PTR_WIDTH  = 1,
  parameter int ADDR_WIDTH = 9,
  parameter int Q_WIDTH    = 64,
  parameter int CNT_WIDTH  = 16
);

  // Frame control
  logic                            enable;
  logic                            former_enable;
  logic                            former_reset;
  logic                            former_done;
  logic                            next_enable;
  logic                            next_reset;
  logic                            next_done;

  // Producer-side memory port
  logic [ADDR_WIDTH-1:0]           former_addr_a;
  logic [ADDR_WIDTH-1:0]           former_addr_b;
  logic                            former_rden_a;
  logic                            former_rden_b;
  logic                            former_wren_a;
  logic                            former_wren_b;
  logic [Q_WIDTH-1:0]              former_q_a;
  logic [Q_WIDTH-1:0]              former_q_b;

  // Consumer-side memory port
  logic [ADDR_WIDTH-1:0]           next_addr_a;
  logic [ADDR_WIDTH-1:0]           next_addr_b;
  logic                            next_rden_a;
  logic                            next_rden_b;
  logic                            next_wren_a;
  logic                            next_wren_b;
  logic [Q_WIDTH-1:0]              next_q_a;
  logic [Q_WIDTH-1:0]              next_q_b;

  // Per-bank RAM ports, bank i in slice i
  logic [NUM_BANKS*ADDR_WIDTH-1:0] bank_addr_a;
  logic [NUM_BANKS*ADDR_WIDTH-1:0] bank_addr_b;
  logic [NUM_BANKS-1:0]            bank_rden_a;
  logic [NUM_BANKS-1:0]            bank_rden_b;
  logic [NUM_BANKS-1:0]            bank_wren_a;
  logic [NUM_BANKS-1:0]            bank_wren_b;
  logic [NUM_BANKS*Q_WIDTH-1:0]    bank_q_a_all;
  logic [NUM_BANKS*Q_WIDTH-1:0]    bank_q_b_all;

  // Status
  logic [PTR_WIDTH:0]              occupancy;
  logic [CNT_WIDTH-1:0]            frames_out;
  logic                            err;

  modport slave (
    input  enable, former_done, next_done,
    input  former_addr_a, former_addr_b, former_rden_a, former_rden_b,
    input  former_wren_a, former_wren_b,
    input  next_addr_a, next_addr_b, next_rden_a, next_rden_b,
    input  next_wren_a, next_wren_b,
    input  bank_q_a_all, bank_q_b_all,
    output former_enable, former_reset, next_enable, next_reset,
    output former_q_a, former_q_b, next_q_a, next_q_b,
    output bank_addr_a, bank_addr_b, bank_rden_a, bank_rden_b,
    output bank_wren_a, bank_wren_b,
    output occupancy, frames_out, err
  );

  modport master (
    output enable, former_done, next_done,
    output former_addr_a, former_addr_b, former_rden_a, former_rden_b,
    output former_wren_a, former_wren_b,
    output next_addr_a, next_addr_b, next_rden_a, next_rden_b,
    output next_wren_a, next_wren_b,
    output bank_q_a_all, bank_q_b_all,
    input  former_enable, former_reset, next_enable, next_reset,
    input  former_q_a, former_q_b, next_q_a, next_q_b,
    input  bank_addr_a, bank_addr_b, bank_rden_a, bank_rden_b,
    input  bank_wren_a, bank_wren_b,
    input  occupancy, frames_out, err
  );

endinterface

// File: rtl/layer_inter_bank_control.sv
// Inter-layer buffer controller. NUM_BANKS feature-map RAM banks form a
// circular queue: the producer fills bank[wr_ptr] while the consumer drains
// bank[rd_ptr]. Each bank is FREE, FILLING, FULL or DRAINING; two small
// FSMs sequence the layers' reset/enable, and the bank ports are steered
// combinationally from the registered bank states.
module layer_inter_bank_control #(
  parameter int NUM_BANKS  = 2,
  parameter int PTR_WIDTH  = 1,
  parameter int ADDR_WIDTH = 9,
  parameter int Q_WIDTH    = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  layer_inter_bank_control_if.slave bus
);

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_DRAINING} bank_state_t;
  typedef enum logic [1:0] {P_IDLE, P_RST, P_RUN} p_state_t;
  typedef enum logic [1:0] {C_IDLE, C_RST, C_RUN} c_state_t;

  bank_state_t          r_bank_state     [NUM_BANKS];
  bank_state_t          w_bank_state_nxt [NUM_BANKS];
  p_state_t             r_p_state, w_p_state_nxt;
  c_state_t             r_c_state, w_c_state_nxt;
  logic [PTR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_WIDTH-1:0] r_frames_out;
  logic                 r_err;

  logic                 w_p_start, w_p_finish;
  logic                 w_c_start, w_c_finish;
  logic                 w_stray_done;
  logic [PTR_WIDTH:0]   w_occupancy;
  logic [Q_WIDTH-1:0]   w_q_a [NUM_BANKS];
  logic [Q_WIDTH-1:0]   w_q_b [NUM_BANKS];

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
    if (ptr == PTR_WIDTH'(NUM_BANKS - 1)) return '0;
    return ptr + 1'b1;
  endfunction

  // Producer FSM: claim the bank at wr_ptr once it is FREE, pulse reset, run to done
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    w_p_state_nxt = r_p_state;
    w_p_start     = 1'b0;
    w_p_finish    = 1'b0;
    case (r_p_state)
      P_IDLE: begin
        if (bus.enable && (r_bank_state[r_wr_ptr] == B_FREE)) begin
          w_p_state_nxt = P_RST;
          w_p_start     = 1'b1;
        end
      end
      P_RST:   w_p_state_nxt = P_RUN;
      P_RUN: begin
        if (bus.former_done) begin
          w_p_state_nxt = P_IDLE;
          w_p_finish    = 1'b1;
        end
      end
      default: w_p_state_nxt = P_IDLE;
    endcase
  end

  // Consumer FSM: drain whenever the bank at rd_ptr is FULL, regardless of enable
  always_comb begin
    w_c_state_nxt = r_c_state;
    w_c_start     = 1'b0;
    w_c_finish    = 1'b0;
    case (r_c_state)
      C_IDLE: begin
        if (r_bank_state[r_rd_ptr] == B_FULL) begin
          w_c_state_nxt = C_RST;
          w_c_start     = 1'b1;
        end
      end
      C_RST:   w_c_state_nxt = C_RUN;
      C_RUN: begin
        if (bus.next_done) begin
          w_c_state_nxt = C_IDLE;
          w_c_finish    = 1'b1;
        end
      end
      default: w_c_state_nxt = C_IDLE;
    endcase
  end

  // A done pulse outside the matching RUN state is a protocol error and is otherwise ignored
  assign w_stray_done = (bus.former_done && (r_p_state != P_RUN)) ||
                        (bus.next_done   && (r_c_state != C_RUN));

  // Bank ownership updates; producer and consumer events always hit different banks
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      w_bank_state_nxt[i] = r_bank_state[i];
      if (r_wr_ptr == PTR_WIDTH'(i)) begin
        if (w_p_start)       w_bank_state_nxt[i] = B_FILLING;
        else if (w_p_finish) w_bank_state_nxt[i] = B_FULL;
      end
      if (r_rd_ptr == PTR_WIDTH'(i)) begin
        if (w_c_start)       w_bank_state_nxt[i] = B_DRAINING;
        else if (w_c_finish) w_bank_state_nxt[i] = B_FREE;
      end
    end
  end

  // State, pointer and counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_p_state    <= P_IDLE;
      r_c_state    <= C_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_frames_out <= '0;
      r_err        <= 1'b0;
      // NOTE: this is a handful of flops of bank status, not RAM, so resetting it is cheap and required.
      for (int i = 0; i < NUM_BANKS; i++) r_bank_state[i] <= B_FREE;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      r_p_state <= w_p_state_nxt;
      r_c_state <= w_c_state_nxt;
      for (int i = 0; i < NUM_BANKS; i++) r_bank_state[i] <= w_bank_state_nxt[i];
      if (w_p_finish) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_c_finish) begin
        r_rd_ptr     <= ptr_inc(r_rd_ptr);
        r_frames_out <= r_frames_out + 1'b1;
      end
      if (w_stray_done) r_err <= 1'b1;
    end
  end

  // Occupancy counts banks holding a finished frame (FULL or DRAINING)
  always_comb begin
    w_occupancy = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if ((r_bank_state[i] == B_FULL) || (r_bank_state[i] == B_DRAINING))
        w_occupancy = w_occupancy + 1'b1;
    end
  end

  // Route producer ports to the FILLING bank and consumer ports to the DRAINING bank
  always_comb begin
    bus.bank_addr_a = '0;
    bus.bank_addr_b = '0;
    bus.bank_rden_a = '0;
    bus.bank_rden_b = '0;
    bus.bank_wren_a = '0;
    bus.bank_wren_b = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      case (r_bank_state[i])
        B_FILLING: begin
          bus.bank_addr_a[i*ADDR_WIDTH +: ADDR_WIDTH] = bus.former_addr_a;
          bus.bank_addr_b[i*ADDR_WIDTH +: ADDR_WIDTH] = bus.former_addr_b;
          bus.bank_rden_a[i] = bus.former_rden_a;
          bus.bank_rden_b[i] = bus.former_rden_b;
          bus.bank_wren_a[i] = bus.former_wren_a;
          bus.bank_wren_b[i] = bus.former_wren_b;
        end
        B_DRAINING: begin
          bus.bank_addr_a[i*ADDR_WIDTH +: ADDR_WIDTH] = bus.next_addr_a;
          bus.bank_addr_b[i*ADDR_WIDTH +: ADDR_WIDTH] = bus.next_addr_b;
          bus.bank_rden_a[i] = bus.next_rden_a;
          bus.bank_rden_b[i] = bus.next_rden_b;
          bus.bank_wren_a[i] = bus.next_wren_a;
          bus.bank_wren_b[i] = bus.next_wren_b;
        end
        default: ;
      endcase
    end
  end

  // Split the flat read-data buses into per-bank words for pointer selection
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_q_split
    assign w_q_a[g] = bus.bank_q_a_all[g*Q_WIDTH +: Q_WIDTH];
    assign w_q_b[g] = bus.bank_q_b_all[g*Q_WIDTH +: Q_WIDTH];
  end

  assign bus.former_q_a    = w_q_a[r_wr_ptr];
  assign bus.former_q_b    = w_q_b[r_wr_ptr];
  assign bus.next_q_a      = w_q_a[r_rd_ptr];
  assign bus.next_q_b      = w_q_b[r_rd_ptr];

  assign bus.former_enable = (r_p_state == P_RUN);
  assign bus.former_reset  = (r_p_state == P_RST);
  assign bus.next_enable   = (r_c_state == C_RUN);
  assign bus.next_reset    = (r_c_state == C_RST);
  assign bus.occupancy     = w_occupancy;
  assign bus.frames_out    = r_frames_out;
  assign bus.err           = r_err;

endmodule

// File: tb/tb_layer_inter_bank_control.sv
// Bench for layer_inter_bank_control with four banks. The bench plays both
// producer and consumer layers and keeps a frame-count reference model:
// n_prod / n_cons are frames finished by each side, so the write bank is
// n_prod mod NB, the read bank is n_cons mod NB, and occupancy is their
// difference. Bus data and frame lengths are randomized.
module tb_layer_inter_bank_control;

  localparam int NB = 4;
  localparam int PW = 2;
  localparam int AW = 9;
  localparam int QW = 64;
  localparam int CW = 16;

  logic clock;
  logic reset;

  layer_inter_bank_control_if #(
    .NUM_BANKS(NB), .PTR_WIDTH(PW), .ADDR_WIDTH(AW), .Q_WIDTH(QW), .CNT_WIDTH(CW)
  ) bus ();

  layer_inter_bank_control #(
    .NUM_BANKS(NB), .PTR_WIDTH(PW), .ADDR_WIDTH(AW), .Q_WIDTH(QW), .CNT_WIDTH(CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0 idle, 1 reset pulse, 2 running
  int mp, mc;
  int n_prod, n_cons;
  int m_err;
  int p_run, c_run;
  int p_len, c_len;
  int occ_max;
  bit force_fd, force_nd, dir_1a5;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mp = 0; mc = 0; n_prod = 0; n_cons = 0; m_err = 0; p_run = 0; c_run = 0;
  endtask

  task automatic model_update(input bit en, input bit fd, input bit nd);
    bit ps, cs;
    ps = (mp == 0) && en && ((n_prod - n_cons) < NB);
    cs = (mc == 0) && (n_prod > n_cons);
    if (fd && mp != 2) m_err = 1;
    if (nd && mc != 2) m_err = 1;
    p_run = (mp == 2 && !fd) ? p_run + 1 : 0;
    c_run = (mc == 2 && !nd) ? c_run + 1 : 0;
    if (mp == 2 && fd) n_prod++;
    if (mc == 2 && nd) n_cons++;
    mp = (mp == 0) ? (ps ? 1 : 0) : (mp == 1) ? 2 : (fd ? 0 : 2);
    mc = (mc == 0) ? (cs ? 1 : 0) : (mc == 1) ? 2 : (nd ? 0 : 2);
  endtask

  task automatic drive_inputs();
    bus.former_addr_a = AW'($urandom);
    bus.former_addr_b = AW'($urandom);
    bus.next_addr_a   = AW'($urandom);
    bus.next_addr_b   = AW'($urandom);
    bus.former_rden_a = 1'($urandom);
    bus.former_rden_b = 1'($urandom);
    bus.former_wren_a = 1'($urandom);
    bus.former_wren_b = 1'($urandom);
    bus.next_rden_a   = 1'($urandom);
    bus.next_rden_b   = 1'($urandom);
    bus.next_wren_a   = 1'($urandom);
    bus.next_wren_b   = 1'($urandom);
    for (int i = 0; i < NB*QW/32; i++) begin
      bus.bank_q_a_all[i*32 +: 32] = $urandom;
      bus.bank_q_b_all[i*32 +: 32] = $urandom;
    end
    bus.former_done = ((mp == 2) && (p_run == p_len - 1)) || force_fd;
    bus.next_done   = ((mc == 2) && (c_run == c_len - 1)) || force_nd;
  endtask

  task automatic check_outputs();
    logic [NB*AW-1:0] e_addr_a, e_addr_b;
    logic [NB-1:0]    e_rden_a, e_rden_b, e_wren_a, e_wren_b;
    int fi, di;
    fi = n_prod % NB;
    di = n_cons % NB;
    e_addr_a = '0; e_addr_b = '0;
    e_rden_a = '0; e_rden_b = '0; e_wren_a = '0; e_wren_b = '0;
    if (mp != 0) begin
      e_addr_a[fi*AW +: AW] = bus.former_addr_a;
      e_addr_b[fi*AW +: AW] = bus.former_addr_b;
      e_rden_a[fi] = bus.former_rden_a;
      e_rden_b[fi] = bus.former_rden_b;
      e_wren_a[fi] = bus.former_wren_a;
      e_wren_b[fi] = bus.former_wren_b;
    end
    if (mc != 0) begin
      e_addr_a[di*AW +: AW] = bus.next_addr_a;
      e_addr_b[di*AW +: AW] = bus.next_addr_b;
      e_rden_a[di] = bus.next_rden_a;
      e_rden_b[di] = bus.next_rden_b;
      e_wren_a[di] = bus.next_wren_a;
      e_wren_b[di] = bus.next_wren_b;
    end
    check("former_enable", bus.former_enable, mp == 2);
    check("former_reset",  bus.former_reset,  mp == 1);
    check("next_enable",   bus.next_enable,   mc == 2);
    check("next_reset",    bus.next_reset,    mc == 1);
    check("occupancy",     bus.occupancy,     n_prod - n_cons);
    check("frames_out",    bus.frames_out,    n_cons % 65536);
    check("err",           bus.err,           m_err);
    check("bank_addr_a",   bus.bank_addr_a,   e_addr_a);
    check("bank_addr_b",   bus.bank_addr_b,   e_addr_b);
    check("bank_rden_a",   bus.bank_rden_a,   e_rden_a);
    check("bank_rden_b",   bus.bank_rden_b,   e_rden_b);
    check("bank_wren_a",   bus.bank_wren_a,   e_wren_a);
    check("bank_wren_b",   bus.bank_wren_b,   e_wren_b);
    check("former_q_a",    bus.former_q_a,    bus.bank_q_a_all[fi*QW +: QW]);
    check("former_q_b",    bus.former_q_b,    bus.bank_q_b_all[fi*QW +: QW]);
    check("next_q_a",      bus.next_q_a,      bus.bank_q_a_all[di*QW +: QW]);
    check("next_q_b",      bus.next_q_b,      bus.bank_q_b_all[di*QW +: QW]);
  endtask

  // One clock cycle: drive at edge+1, check at edge+2, advance past the next edge
  task automatic step();
    bit fd, nd, en;
    int occ_before;
    drive_inputs();
    if (dir_1a5) begin
      bus.former_addr_a = 9'h1A5;
      bus.former_wren_a = 1'b1;
      bus.former_rden_a = 1'b0;
      bus.next_wren_a   = 1'b0;
      bus.next_rden_a   = 1'b0;
    end
    #1;
    check_outputs();
    if (dir_1a5) begin
      check("dir_bank_wren_a",  bus.bank_wren_a,       4'b0010);
      check("dir_bank1_addr_a", bus.bank_addr_a[17:9], 9'h1A5);
      check("dir_bank_rden_a",  bus.bank_rden_a,       4'b0000);
      check("dir_next_q_a",     bus.next_q_a,          bus.bank_q_a_all[63:0]);
    end
    if (int'(bus.occupancy) > occ_max) occ_max = int'(bus.occupancy);
    fd = bus.former_done;
    nd = bus.next_done;
    en = bus.enable;
    occ_before = n_prod - n_cons;
    @(posedge clock);
    #1;
    model_update(en, fd, nd);
    if (fd && nd) begin
      check("sim_done_occupancy", bus.occupancy, occ_before);
      check("sim_done_err",       bus.err,       m_err);
    end
  endtask

  // Assert reset between edges and confirm outputs clear without a clock
  task automatic apply_reset();
    bus.enable      = 1'b0;
    bus.former_done = 1'b0;
    bus.next_done   = 1'b0;
    force_fd = 1'b0;
    force_nd = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_former_enable", bus.former_enable, 0);
    check("rst_former_reset",  bus.former_reset,  0);
    check("rst_next_enable",   bus.next_enable,   0);
    check("rst_next_reset",    bus.next_reset,    0);
    check("rst_occupancy",     bus.occupancy,     0);
    check("rst_frames_out",    bus.frames_out,    0);
    check("rst_err",           bus.err,           0);
    check("rst_bank_addr_a",   bus.bank_addr_a,   0);
    check("rst_bank_addr_b",   bus.bank_addr_b,   0);
    check("rst_bank_rden_a",   bus.bank_rden_a,   0);
    check("rst_bank_rden_b",   bus.bank_rden_b,   0);
    check("rst_bank_wren_a",   bus.bank_wren_a,   0);
    check("rst_bank_wren_b",   bus.bank_wren_b,   0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    force_fd = 1'b0; force_nd = 1'b0; dir_1a5 = 1'b0;
    bus.enable = 1'b0; bus.former_done = 1'b0; bus.next_done = 1'b0;
    bus.former_addr_a = '0; bus.former_addr_b = '0;
    bus.next_addr_a = '0;   bus.next_addr_b = '0;
    bus.former_rden_a = 1'b0; bus.former_rden_b = 1'b0;
    bus.former_wren_a = 1'b0; bus.former_wren_b = 1'b0;
    bus.next_rden_a = 1'b0;   bus.next_rden_b = 1'b0;
    bus.next_wren_a = 1'b0;   bus.next_wren_b = 1'b0;
    bus.bank_q_a_all = '0;  bus.bank_q_b_all = '0;
    p_len = 10; c_len = 10; occ_max = 0;
    model_reset();
    @(posedge clock);
    #1;

    // Balanced producer/consumer, 10-cycle frames
    apply_reset();
    bus.enable = 1'b1;
    step();
    check("cyc1_former_reset",  bus.former_reset,  1);
    check("cyc1_former_enable", bus.former_enable, 0);
    for (int k = 0; k < 100 && !(mp == 2 && p_run == p_len - 1); k++) step();
    step();
    check("lat1_next_reset", bus.next_reset, 0);
    step();
    check("lat2_next_reset", bus.next_reset, 1);
    for (int k = 0; k < 100 && !(mp == 2 && n_prod == 1 && mc == 2); k++) step();
    dir_1a5 = 1'b1;
    step();
    dir_1a5 = 1'b0;
    for (int k = 0; k < 400 && n_cons < 4; k++) step();
    check("frames_out_4", bus.frames_out, 4);
    check("err_clean",    bus.err,        0);

    // Fast producer, slow consumer: queue fills and the producer waits
    apply_reset();
    p_len = 10; c_len = 50; occ_max = 0;
    bus.enable = 1'b1;
    for (int k = 0; k < 1000 && n_cons < 2; k++) step();
    check("slow_occ_max", occ_max, NB);

    // Stray done pulses set the sticky error flag
    apply_reset();
    p_len = 10; c_len = 10;
    step();
    force_nd = 1'b1;
    step();
    force_nd = 1'b0;
    check("stray_next_err",        bus.err,         1);
    check("stray_next_frames_out", bus.frames_out,  0);
    check("stray_next_occupancy",  bus.occupancy,   0);
    check("stray_next_enable",     bus.next_enable, 0);
    repeat (5) step();
    check("stray_err_sticky", bus.err, 1);
    apply_reset();
    force_fd = 1'b1;
    step();
    force_fd = 1'b0;
    check("stray_former_err", bus.err, 1);
    bus.enable = 1'b1;
    step();
    check("stray_former_then_start", bus.former_reset, 1);

    // Random frame lengths, 10 frames with enable dropped during frame 10
    apply_reset();
    p_len = $urandom_range(4, 14);
    c_len = $urandom_range(4, 30);
    bus.enable = 1'b1;
    for (int k = 0; k < 3000 && !(n_prod == 9 && mp == 2 && p_run == p_len / 2); k++) step();
    bus.enable = 1'b0;
    for (int k = 0; k < 3000 && !(mp == 0 && mc == 0 && n_prod == n_cons); k++) step();
    repeat (20) step();
    check("drain_frames_out",    bus.frames_out,    10);
    check("drain_occupancy",     bus.occupancy,     0);
    check("drain_former_enable", bus.former_enable, 0);
    check("drain_err",           bus.err,           0);

    // Reset in the middle of a frame, then restart
    bus.enable = 1'b1;
    for (int k = 0; k < 200 && !(mp == 2 && p_run == 2); k++) step();
    apply_reset();
    bus.enable = 1'b1;
    step();
    check("restart_former_reset", bus.former_reset, 1);
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
